// File: rtl/ls_writeback_arbiter_pkg.sv
// Shared widths and entry field offsets for the load/store write-back arbiter.
// An entry is {addr, data}, with the address in the upper bits.
package ls_writeback_arbiter_pkg;
   localparam int LS_WB_AW     = 4;
   localparam int LS_WB_DW     = 32;
   localparam int ENT_DATA_LSB = 0;
   localparam int ENT_DATA_MSB = LS_WB_DW - 1;
   localparam int ENT_ADDR_LSB = LS_WB_DW;
   localparam int ENT_ADDR_MSB = LS_WB_DW + LS_WB_AW - 1;
   localparam int ENT_W        = LS_WB_AW + LS_WB_DW;
endpackage

// File: rtl/ls_writeback_arbiter_if.sv
// Request, register-file write, status and forwarding signals of the write-back arbiter.
// The master modport is the load/store side; the slave modport is the arbiter.
interface ls_writeback_arbiter_if
   import ls_writeback_arbiter_pkg::*;
#(
   parameter int AW = LS_WB_AW,
   parameter int DW = LS_WB_DW
);
   logic          WB_EN;
   logic [AW-1:0] WB_Addr;
   logic [DW-1:0] WB_data;
   logic          L_EN;
   logic [AW-1:0] L_Addr;
   logic [DW-1:0] L_data;
   logic          RF_WE;
   logic [AW-1:0] RF_Addr;
   logic [DW-1:0] RF_Data;
   logic          STALL;
   logic          OVF;
   logic [AW-1:0] FWD_Addr;
   logic          FWD_Hit;
   logic [DW-1:0] FWD_Data;

   modport master (
      output WB_EN, WB_Addr, WB_data, L_EN, L_Addr, L_data, FWD_Addr,
      input  RF_WE, RF_Addr, RF_Data, STALL, OVF, FWD_Hit, FWD_Data
   );

   modport slave (
      input  WB_EN, WB_Addr, WB_data, L_EN, L_Addr, L_data, FWD_Addr,
      output RF_WE, RF_Addr, RF_Data, STALL, OVF, FWD_Hit, FWD_Data
   );
endinterface

// File: rtl/ls_writeback_arbiter_fifo.sv
// ls_wb_fifo: circular buffer, one pop and up to two pushes per cycle.
// The caller only raises wr1 together with wr0 and never overfills the buffer.
module ls_wb_fifo #(
   parameter int DEPTH = 4,
   parameter int EW    = 36
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          pop,
   input  logic                          wr0,
   input  logic [EW-1:0]                 wr0_ent,
   input  logic                          wr1,
   input  logic [EW-1:0]                 wr1_ent,
   output logic [EW-1:0]                 head,
   output logic [$clog2(DEPTH)-1:0]      rd_ptr,
   output logic [$clog2(DEPTH)-1:0]      wr_ptr,
   output logic [$clog2(DEPTH):0]        count,
   output logic [DEPTH-1:0][EW-1:0]      ents
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   assign head = ents[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         wr_ptr <= wr_ptr + PW'(wr0) + PW'(wr1);
         count  <= count + CW'(wr0) + CW'(wr1) - CW'(pop);
      end
   end

   // Storage needs no reset: only slots inside [rd_ptr, rd_ptr+count) are ever read.
   always_ff @(posedge clk) begin
      if (wr0) ents[wr_ptr] <= wr0_ent;
      if (wr1) ents[wr_ptr + PW'(1)] <= wr1_ent;
   end
endmodule

// File: rtl/ls_writeback_arbiter.sv
// Serialises base write-back and load writes onto one register-file write port.
// Optional forwarding search over pending writes is built when LS_WB_FORWARD_EN is defined.
module ls_writeback_arbiter
   import ls_writeback_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = LS_WB_AW,
   parameter int DW    = LS_WB_DW
) (
   input  logic                    CLK,
   input  logic                    RST,
   ls_writeback_arbiter_if.slave   bus
);
   localparam int EW = AW + DW;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [EW-1:0]            head;
   logic [PW-1:0]            rd_ptr, wr_ptr;
   logic [CW-1:0]            count, count_next;
   logic [DEPTH-1:0][EW-1:0] ents;

   logic          rf_we, stall, ovf;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_data;

   // Same-register conflict within a cycle: the load wins.
   logic          wb_keep;
   logic [EW-1:0] wb_ent, l_ent;
   assign wb_keep = bus.WB_EN & ~(bus.L_EN & (bus.WB_Addr == bus.L_Addr));
   assign wb_ent  = {bus.WB_Addr, bus.WB_data};
   assign l_ent   = {bus.L_Addr, bus.L_data};

   // New requests compacted into age order.
   logic          n0_v, n1_v;
   logic [EW-1:0] n0, n1;
   assign n0_v = wb_keep | bus.L_EN;
   assign n0   = wb_keep ? wb_ent : l_ent;
   assign n1_v = wb_keep & bus.L_EN;
   assign n1   = l_ent;

   // A non-empty queue always supplies the oldest candidate, else the oldest new request bypasses.
   logic          pop, out_v;
   logic [EW-1:0] out_ent;
   assign pop     = (count != '0);
   assign out_v   = pop | n0_v;
   assign out_ent = pop ? head : n0;

   logic          e0_v, e1_v, acc1, ovf_set;
   logic [EW-1:0] e0;
   assign e0_v = pop ? n0_v : n1_v;
   assign e0   = pop ? n0 : n1;
   assign e1_v = pop & n1_v;

   // After a pop at least one slot is free, so only the second push can miss (full queue).
   assign acc1       = e1_v & (count != DEPTH_C);
   assign ovf_set    = e1_v & (count == DEPTH_C);
   assign count_next = count + CW'(e0_v) + CW'(acc1) - CW'(pop);

   ls_wb_fifo #(.DEPTH(DEPTH), .EW(EW)) u_fifo (
      .clk     (CLK),
      .rst     (RST),
      .pop     (pop),
      .wr0     (e0_v),
      .wr0_ent (e0),
      .wr1     (acc1),
      .wr1_ent (n1),
      .head    (head),
      .rd_ptr  (rd_ptr),
      .wr_ptr  (wr_ptr),
      .count   (count),
      .ents    (ents)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         rf_we   <= 1'b0;
         rf_addr <= '0;
         rf_data <= '0;
         stall   <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         rf_we <= out_v;
         if (out_v) begin
            rf_addr <= out_ent[EW-1 -: AW];
            rf_data <= out_ent[DW-1:0];
         end
         stall <= (DEPTH_C - count_next) < CW'(2);
         if (ovf_set) ovf <= 1'b1;
      end
   end

   assign bus.RF_WE   = rf_we;
   assign bus.RF_Addr = rf_addr;
   assign bus.RF_Data = rf_data;
   assign bus.STALL   = stall;
   assign bus.OVF     = ovf;

`ifdef LS_WB_FORWARD_EN
   // Scan oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      bus.FWD_Hit  = 1'b0;
      bus.FWD_Data = '0;
      if (rf_we && rf_addr == bus.FWD_Addr) begin
         bus.FWD_Hit  = 1'b1;
         bus.FWD_Data = rf_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count && ents[rd_ptr + PW'(i)][EW-1 -: AW] == bus.FWD_Addr) begin
            bus.FWD_Hit  = 1'b1;
            bus.FWD_Data = ents[rd_ptr + PW'(i)][DW-1:0];
         end
      end
      if (wb_keep && bus.WB_Addr == bus.FWD_Addr) begin
         bus.FWD_Hit  = 1'b1;
         bus.FWD_Data = bus.WB_data;
      end
      if (bus.L_EN && bus.L_Addr == bus.FWD_Addr) begin
         bus.FWD_Hit  = 1'b1;
         bus.FWD_Data = bus.L_data;
      end
   end

   logic unused_sig;
   assign unused_sig = ^wr_ptr;
`else
   assign bus.FWD_Hit  = 1'b0;
   assign bus.FWD_Data = '0;

   logic unused_sig;
   assign unused_sig = ^{wr_ptr, rd_ptr, ents, bus.FWD_Addr};
`endif
endmodule

// File: tb/tb_ls_writeback_arbiter.sv
// Bench for ls_writeback_arbiter: queue-level reference model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_ls_writeback_arbiter;
   import ls_writeback_arbiter_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ls_writeback_arbiter_if bus ();

   ls_writeback_arbiter #(.DEPTH(DEPTH)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a list of pending writes in age order.
   logic [ENT_W-1:0] mq[$];
   logic             m_we = 1'b0, m_stall = 1'b0, m_ovf = 1'b0;
   logic [3:0]       m_addr = '0;
   logic [31:0]      m_data = '0;
   bit               started = 1'b0;

   always @(posedge clk) begin
      logic [ENT_W-1:0] lst[$];
      logic [ENT_W-1:0] e;
      started = 1'b1;
      if (rst) begin
         mq.delete();
         m_we = 1'b0; m_addr = '0; m_data = '0; m_stall = 1'b0; m_ovf = 1'b0;
      end else begin
         lst = mq;
         if (bus.WB_EN && !(bus.L_EN && bus.WB_Addr == bus.L_Addr))
            lst.push_back({bus.WB_Addr, bus.WB_data});
         if (bus.L_EN)
            lst.push_back({bus.L_Addr, bus.L_data});
         if (lst.size() > 0) begin
            e = lst.pop_front();
            m_we = 1'b1;
            m_addr = e[ENT_ADDR_MSB:ENT_ADDR_LSB];
            m_data = e[ENT_DATA_MSB:ENT_DATA_LSB];
         end else begin
            m_we = 1'b0;
         end
         while (lst.size() > DEPTH) begin
            void'(lst.pop_back());
            m_ovf = 1'b1;
         end
         mq = lst;
         m_stall = (DEPTH - lst.size()) < 2;
      end
   end

   // Youngest-first forwarding lookup.
   task automatic model_fwd(output logic hit, output logic [31:0] data);
      hit = 1'b0; data = '0;
`ifdef LS_WB_FORWARD_EN
      if (bus.L_EN && bus.L_Addr == bus.FWD_Addr) begin
         hit = 1'b1; data = bus.L_data;
      end else if (bus.WB_EN && !(bus.L_EN && bus.WB_Addr == bus.L_Addr) &&
                   bus.WB_Addr == bus.FWD_Addr) begin
         hit = 1'b1; data = bus.WB_data;
      end else begin
         for (int i = mq.size() - 1; i >= 0 && !hit; i--) begin
            if (mq[i][ENT_ADDR_MSB:ENT_ADDR_LSB] == bus.FWD_Addr) begin
               hit = 1'b1; data = mq[i][ENT_DATA_MSB:ENT_DATA_LSB];
            end
         end
         if (!hit && m_we && m_addr == bus.FWD_Addr) begin
            hit = 1'b1; data = m_data;
         end
      end
`endif
   endtask

   always @(negedge clk) begin
      logic        fh;
      logic [31:0] fd;
      if (started) begin
         model_fwd(fh, fd);
         chk("mdl_rf_we",   32'(bus.RF_WE),   32'(m_we));
         chk("mdl_rf_addr", 32'(bus.RF_Addr), 32'(m_addr));
         chk("mdl_rf_data", bus.RF_Data,      m_data);
         chk("mdl_stall",   32'(bus.STALL),   32'(m_stall));
         chk("mdl_ovf",     32'(bus.OVF),     32'(m_ovf));
         chk("mdl_fwd_hit", 32'(bus.FWD_Hit), 32'(fh));
         chk("mdl_fwd_data", bus.FWD_Data,    fd);
      end
   end

   // Apply one cycle of requests; returns 1 time unit after the sampling edge.
   task automatic cyc(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                      input logic le, input logic [3:0] la, input logic [31:0] ld);
      bus.WB_EN = we; bus.WB_Addr = wa; bus.WB_data = wd;
      bus.L_EN  = le; bus.L_Addr  = la; bus.L_data  = ld;
      @(posedge clk); #1;
   endtask

   task automatic idle();
      cyc(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
   endtask

   task automatic chk_rf(input string name, input logic we, input logic [3:0] a, input logic [31:0] d);
      chk({name, "_we"},   32'(bus.RF_WE),   32'(we));
      chk({name, "_addr"}, 32'(bus.RF_Addr), 32'(a));
      chk({name, "_data"}, bus.RF_Data,      d);
   endtask

   initial begin
      bus.FWD_Addr = '0;
      bus.WB_EN = 1'b0; bus.WB_Addr = '0; bus.WB_data = '0;
      bus.L_EN  = 1'b0; bus.L_Addr  = '0; bus.L_data  = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_rf("reset", 1'b0, 4'd0, 32'd0);
      chk("reset_stall", 32'(bus.STALL), 32'd0);
      chk("reset_ovf",   32'(bus.OVF),   32'd0);
      rst = 1'b0;

      // Single load into an empty queue: visible next cycle, nothing queued.
      cyc(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'hDEADBEEF);
      chk_rf("t1", 1'b1, 4'd3, 32'hDEADBEEF);
      chk("t1_stall", 32'(bus.STALL), 32'd0);
      idle();
      chk_rf("t1_done", 1'b0, 4'd3, 32'hDEADBEEF);

      // WB and L to different registers retire WB first.
      cyc(1'b1, 4'd1, 32'h100, 1'b1, 4'd2, 32'h55);
      chk_rf("t2_a", 1'b1, 4'd1, 32'h100);
      idle();
      chk_rf("t2_b", 1'b1, 4'd2, 32'h55);
      idle();
      chk("t2_done", 32'(bus.RF_WE), 32'd0);

      // Same-register conflict keeps only the load.
      cyc(1'b1, 4'd4, 32'h200, 1'b1, 4'd4, 32'h77);
      chk_rf("t3", 1'b1, 4'd4, 32'h77);
      idle();
      chk("t3_single", 32'(bus.RF_WE), 32'd0);
      chk("t3_ovf",    32'(bus.OVF),   32'd0);

      // Three dual cycles: STALL rises when three entries wait.
      cyc(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h12);
      chk_rf("t4_1", 1'b1, 4'd1, 32'h11);
      chk("t4_stall1", 32'(bus.STALL), 32'd0);
      cyc(1'b1, 4'd3, 32'h13, 1'b1, 4'd4, 32'h14);
      chk_rf("t4_2", 1'b1, 4'd2, 32'h12);
      chk("t4_stall2", 32'(bus.STALL), 32'd0);
      cyc(1'b1, 4'd5, 32'h15, 1'b1, 4'd6, 32'h16);
      chk_rf("t4_3", 1'b1, 4'd3, 32'h13);
      chk("t4_stall3", 32'(bus.STALL), 32'd1);
      idle();
      chk_rf("t4_4", 1'b1, 4'd4, 32'h14);
      chk("t4_stall4", 32'(bus.STALL), 32'd0);
      idle();
      chk_rf("t4_5", 1'b1, 4'd5, 32'h15);
      idle();
      chk_rf("t4_6", 1'b1, 4'd6, 32'h16);
      chk("t4_ovf", 32'(bus.OVF), 32'd0);
      idle();
      chk("t4_done", 32'(bus.RF_WE), 32'd0);

      // Keep pushing pairs until the full queue forces a drop.
      for (int k = 1; k <= 5; k++) begin
         cyc(1'b1, 4'(k), 32'h100 + 32'(k), 1'b1, 4'(k + 8), 32'h200 + 32'(k));
         if (k == 4) begin
            chk_rf("t5_c4", 1'b1, 4'd10, 32'h202);
            chk("t5_c4_ovf",   32'(bus.OVF),   32'd0);
            chk("t5_c4_stall", 32'(bus.STALL), 32'd1);
         end
      end
      chk_rf("t5_c5", 1'b1, 4'd3, 32'h103);
      chk("t5_ovf",   32'(bus.OVF),   32'd1);
      chk("t5_stall", 32'(bus.STALL), 32'd1);
      idle();
      chk_rf("t5_d1", 1'b1, 4'd11, 32'h203);
      chk("t5_ovf_sticky", 32'(bus.OVF), 32'd1);
      rst = 1'b1;
      idle();
      chk_rf("t5_rst", 1'b0, 4'd0, 32'd0);
      chk("t5_rst_stall", 32'(bus.STALL), 32'd0);
      chk("t5_rst_ovf",   32'(bus.OVF),   32'd0);
      rst = 1'b0;
      idle();
      chk("t5_discard", 32'(bus.RF_WE), 32'd0);

      // Two queued writes to R5: lookup sees the younger one.
      bus.FWD_Addr = 4'd5;
      cyc(1'b1, 4'd6, 32'hA, 1'b1, 4'd5, 32'h1);
      cyc(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'h2);
      bus.L_EN = 1'b0;
      #1;
`ifdef LS_WB_FORWARD_EN
      chk("t6_hit",  32'(bus.FWD_Hit), 32'd1);
      chk("t6_data", bus.FWD_Data,     32'h2);
      bus.L_EN = 1'b1; bus.L_Addr = 4'd5; bus.L_data = 32'h3;
      #1;
      chk("t6_incoming_data", bus.FWD_Data, 32'h3);
      bus.L_EN = 1'b0;
`else
      chk("t6_hit",  32'(bus.FWD_Hit), 32'd0);
      chk("t6_data", bus.FWD_Data,     32'h0);
`endif
      @(posedge clk); #1;
      idle();
      idle();

      // Mixed traffic on a small register range to exercise conflicts and overflow.
      for (int i = 0; i < 60; i++) begin
         bus.FWD_Addr = 4'($urandom_range(0, 3));
         cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom,
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom);
      end
      for (int i = 0; i < 8; i++) idle();
      chk("final_drained", 32'(bus.RF_WE), 32'd0);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
